// File: rtl/bus_master_arbiter.sv
// Shared-bus arbiter between the stage-2 CPU control path and external masters.
// Registered outputs; every ownership change passes through one dead cycle.
module bus_master_arbiter #(
    parameter int NUM_EXT  = 2,
    parameter int MAX_HOLD = 16,
    parameter int CPU_MIN  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_bus_request,
    input  logic [NUM_EXT-1:0] ext_req,
    output logic [NUM_EXT-1:0] ext_gnt,
    output logic               cpu_hold,
    output logic [2:0]         bus_owner,
    output logic               bus_idle
);

    localparam logic [2:0] S_CPU   = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_TIN   = 3'd2;
    localparam logic [2:0] S_EXT   = 3'd3;
    localparam logic [2:0] S_TOUT  = 3'd4;

    localparam logic [2:0] OWN_CPU  = 3'd0;
    localparam logic [2:0] OWN_NONE = 3'd7;

    localparam logic [7:0] CPU_MIN_C  = 8'(CPU_MIN);
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [3:0] NUM_EXT_C  = 4'(NUM_EXT);
    localparam logic [2:0] LAST_EXT   = 3'(NUM_EXT - 1);

    logic [2:0] state;
    logic [2:0] rr_ptr;
    logic [2:0] winner;
    logic [7:0] hold_cnt;
    logic [7:0] cpu_cnt;

    logic [7:0] req_pad;
    logic       any_req;
    logic [7:0] cnt_inc;
    logic       cpu_done;
    logic [3:0] idx;
    logic [2:0] pick;
    logic       pick_vld;
    logic [2:0] rr_next;
    logic       release_ext;

    assign req_pad  = 8'(ext_req);
    assign any_req  = |ext_req;
    assign cnt_inc  = (cpu_cnt == 8'hff) ? cpu_cnt : cpu_cnt + 8'd1;
    // Compare the incremented count so CPU_OWN lasts exactly CPU_MIN cycles.
    assign cpu_done = (cnt_inc >= CPU_MIN_C);
    assign rr_next  = (winner == LAST_EXT) ? 3'd0 : winner + 3'd1;

    assign release_ext = !req_pad[winner] || (hold_cnt == MAX_HOLD_C);

    // Round-robin scan; walking downward leaves the nearest match in pick.
    always_comb begin
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= NUM_EXT_C) begin
                idx = idx - NUM_EXT_C;
            end
            if (req_pad[idx[2:0]]) begin
                pick     = idx[2:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_CPU;
            rr_ptr    <= '0;
            winner    <= '0;
            hold_cnt  <= '0;
            cpu_cnt   <= CPU_MIN_C;
            ext_gnt   <= '0;
            cpu_hold  <= 1'b0;
            bus_owner <= OWN_CPU;
            bus_idle  <= 1'b0;
        end else begin
            unique case (state)
                S_CPU: begin
                    cpu_cnt <= cnt_inc;
                    if (any_req && cpu_done) begin
                        state    <= S_DRAIN;
                        cpu_hold <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!any_req) begin
                        state     <= S_TOUT;
                        bus_owner <= OWN_NONE;
                        bus_idle  <= 1'b1;
                    end else if (!cpu_bus_request) begin
                        state     <= S_TIN;
                        bus_owner <= OWN_NONE;
                        bus_idle  <= 1'b1;
                    end
                end
                S_TIN: begin
                    if (pick_vld) begin
                        state     <= S_EXT;
                        winner    <= pick;
                        ext_gnt   <= NUM_EXT'(1) << pick;
                        bus_owner <= pick + 3'd1;
                        bus_idle  <= 1'b0;
                        hold_cnt  <= 8'd1;
                    end else begin
                        state <= S_TOUT;
                    end
                end
                S_EXT: begin
                    if (release_ext) begin
                        state     <= S_TOUT;
                        ext_gnt   <= '0;
                        bus_owner <= OWN_NONE;
                        bus_idle  <= 1'b1;
                        rr_ptr    <= rr_next;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                S_TOUT: begin
                    state     <= S_CPU;
                    cpu_hold  <= 1'b0;
                    bus_owner <= OWN_CPU;
                    bus_idle  <= 1'b0;
                    cpu_cnt   <= '0;
                end
                default: begin
                    state     <= S_CPU;
                    ext_gnt   <= '0;
                    cpu_hold  <= 1'b0;
                    bus_owner <= OWN_CPU;
                    bus_idle  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: latency, drain, tenure limit,
// round-robin order, abandon and asynchronous reset.
module tb_bus_master_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cpu_bus_request;
    logic [1:0] ext_req;
    logic [1:0] ext_gnt;
    logic       cpu_hold;
    logic [2:0] bus_owner;
    logic       bus_idle;

    int n_run  = 0;
    int n_fail = 0;

    bus_master_arbiter #(
        .NUM_EXT (2),
        .MAX_HOLD(16),
        .CPU_MIN (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_bus_request(cpu_bus_request),
        .ext_req        (ext_req),
        .ext_gnt        (ext_gnt),
        .cpu_hold       (cpu_hold),
        .bus_owner      (bus_owner),
        .bus_idle       (bus_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int gnt, input int hold,
                           input int own, input int idle);
        check({tag, "_gnt"}, int'(ext_gnt), gnt);
        check({tag, "_hold"}, int'(cpu_hold), hold);
        check({tag, "_own"}, int'(bus_owner), own);
        check({tag, "_idle"}, int'(bus_idle), idle);
    endtask

    // Counts grant cycles for exp_gnt, then the following CPU_OWN run.
    task automatic tenure(input string tag, input int exp_gnt);
        int n;
        n = 0;
        while (ext_gnt == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_gnt"}, int'(ext_gnt), exp_gnt);
        n = 0;
        while (int'(ext_gnt) == exp_gnt && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_len"}, n, 16);
        chk_out({tag, "_tout"}, 0, 1, 7, 1);
        tick();
        n = 0;
        while (!cpu_hold && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_cpurun"}, n, 4);
    endtask

    // Invariants checked mid-cycle throughout the run.
    always @(negedge clk) begin
        check("inv_onehot", int'($countones(ext_gnt) <= 1), 1);
        if (ext_gnt != 2'b00) check("inv_hold", int'(cpu_hold), 1);
        if (bus_idle) check("inv_idle", int'(ext_gnt), 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        cpu_bus_request = 1'b0;
        ext_req         = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst", 0, 0, 0, 0);

        // Single request, 3-cycle latency, release by request drop
        reset_n = 1'b1;
        ext_req = 2'b01;
        tick();
        chk_out("t1_c1", 0, 1, 0, 0);
        tick();
        chk_out("t1_c2", 0, 1, 7, 1);
        tick();
        chk_out("t1_c3", 1, 1, 1, 0);
        tick();
        tick();
        tick();
        chk_out("t1_c6", 1, 1, 1, 0);
        ext_req = 2'b00;
        tick();
        chk_out("t1_c7", 0, 1, 7, 1);
        tick();
        chk_out("t1_c8", 0, 0, 0, 0);

        // Drain wait while stage 2 still needs the bus
        repeat (6) tick();
        cpu_bus_request = 1'b1;
        ext_req         = 2'b10;
        tick();
        chk_out("t2_drain", 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t2_wait", 0, 1, 0, 0);
        end
        cpu_bus_request = 1'b0;
        tick();
        chk_out("t2_tin", 0, 1, 7, 1);
        tick();
        chk_out("t2_gnt", 2, 1, 2, 0);
        ext_req = 2'b00;
        tick();
        chk_out("t2_tout", 0, 1, 7, 1);
        tick();
        chk_out("t2_cpu", 0, 0, 0, 0);

        // Tenure limit with a request held high
        repeat (6) tick();
        ext_req = 2'b01;
        tick();
        tick();
        check("t3_lat2", int'(ext_gnt), 0);
        tick();
        tenure("t3", 1);
        chk_out("t3_redrain", 0, 1, 0, 0);

        // Round-robin from a fresh reset
        reset_n = 1'b0;
        #1;
        chk_out("t4_rst", 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        ext_req = 2'b11;
        tenure("rr0", 1);
        tenure("rr1", 2);
        tenure("rr2", 1);
        tenure("rr3", 2);

        // Abandoned request while draining
        ext_req = 2'b00;
        repeat (10) tick();
        chk_out("t5_idle", 0, 0, 0, 0);
        cpu_bus_request = 1'b1;
        ext_req         = 2'b01;
        tick();
        chk_out("t5_drain", 0, 1, 0, 0);
        ext_req = 2'b00;
        tick();
        chk_out("t5_tout", 0, 1, 7, 1);
        tick();
        chk_out("t5_cpu", 0, 0, 0, 0);

        // Asynchronous reset during an external tenure
        cpu_bus_request = 1'b0;
        repeat (6) tick();
        ext_req = 2'b01;
        repeat (3) tick();
        chk_out("t6_gnt", 1, 1, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("t6_async", 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("t6_lat2", int'(ext_gnt), 0);
        tick();
        chk_out("t6_regnt", 1, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
